int_responder: RTL and testbench



---
 rtl/int_responder_if.sv | 14 +
 rtl/int_responder.sv | 133 +++++++++++++
 tb/tb_int_responder.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/int_responder_if.sv
// rtl/int_responder_if.sv - Z80 bus signals seen by the interrupt responder
interface int_responder_if;
  logic        m1;
  logic        iorq;
  logic        rd;
  logic        wr;
  logic [15:0] a;
  logic [7:0]  d_in;
  logic [7:0]  d_out;
  logic        d_oe;

  modport master (output m1, iorq, rd, wr, a, d_in, input d_out, d_oe);
  modport slave  (input m1, iorq, rd, wr, a, d_in, output d_out, d_oe);
endinterface

// File: rtl/int_responder.sv
// rtl/int_responder.sv - interrupt source arbiter and IM2 acknowledge responder
module int_responder #(
  parameter logic [15:0] CTRL_PORT  = 16'hBF1F,
  parameter logic [15:0] VEC_PORT   = 16'hBE1F,
  parameter int unsigned FRAME_HOLD = 32
) (
  input  logic            clk28,
  input  logic            rst,
  input  logic            clkcpu_ck,
  int_responder_if.slave  bus,
  input  logic            src_frame,
  input  logic            src_line,
  input  logic            src_ext,
  output logic            n_int
);

  typedef enum logic [1:0] {IDLE, ACK, DONE} state_t;

  state_t      state;
  logic [2:0]  en;
  logic        vec_en;
  logic [4:0]  base;
  logic [2:0]  pend;
  logic [7:0]  hold_cnt;
  logic [1:0]  idx;
  logic [2:0]  src_q;
  logic [2:0]  rise_q;
  logic        ack_q;
  logic        wr_q;

  logic [2:0]  src_now;
  logic [2:0]  masked;
  logic [2:0]  clr;
  logic [1:0]  pick;
  logic        ack_cyc;
  logic        ack_rise;
  logic        io_wr;
  logic        wr_edge;
  logic        ctrl_rd;
  logic        hold_expire;

  assign src_now  = {src_ext, src_line, src_frame};
  assign masked   = pend & en;
  assign ack_cyc  = bus.m1 & bus.iorq;
  assign ack_rise = ack_cyc & ~ack_q;
  assign io_wr    = bus.iorq & bus.wr & ~bus.m1;
  assign wr_edge  = io_wr & ~wr_q;
  assign ctrl_rd  = bus.iorq & bus.rd & ~bus.m1 & (bus.a == CTRL_PORT);
  assign hold_expire = pend[0] & clkcpu_ck & (hold_cnt <= 8'd1);

  always_comb begin
    pick = 2'd3;
    if (masked[2]) pick = 2'd2;
    if (masked[1]) pick = 2'd1;
    if (masked[0]) pick = 2'd0;
  end

  always_comb begin
    clr = 3'b000;
    if (wr_edge && bus.a == CTRL_PORT) clr = bus.d_in[6:4];
    if (state == IDLE && ack_rise && pick != 2'd3) clr = clr | (3'b001 << pick);
    if (hold_expire) clr[0] = 1'b1;
  end

  // Edge history keeps tracking through reset so a bus cycle or source level
  // already in progress when reset releases is not mistaken for a new edge.
  always_ff @(posedge clk28) begin
    src_q <= src_now;
    ack_q <= ack_cyc;
    wr_q  <= io_wr;
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      state     <= IDLE;
      en        <= 3'b001;
      vec_en    <= 1'b0;
      base      <= 5'b11111;
      pend      <= 3'b000;
      hold_cnt  <= 8'd0;
      idx       <= 2'd3;
      rise_q    <= 3'b000;
      n_int     <= 1'b1;
      bus.d_oe  <= 1'b0;
      bus.d_out <= 8'hFF;
    end else begin
      rise_q <= src_now & ~src_q;
      // Sets are applied after clears so a simultaneous set always wins.
      pend   <= (pend & ~clr) | rise_q;

      if (rise_q[0])
        hold_cnt <= 8'(FRAME_HOLD);
      else if (pend[0] && clkcpu_ck && hold_cnt != 8'd0)
        hold_cnt <= hold_cnt - 8'd1;

      if (clkcpu_ck) n_int <= ~|masked;

      if (wr_edge && bus.a == CTRL_PORT) begin
        en     <= bus.d_in[2:0];
        vec_en <= bus.d_in[3];
      end
      if (wr_edge && bus.a == VEC_PORT) base <= bus.d_in[7:3];

      case (state)
        IDLE: begin
          bus.d_oe  <= ctrl_rd;
          bus.d_out <= ctrl_rd ? {1'b0, pend, vec_en, en} : 8'hFF;
          if (ack_rise) begin
            idx   <= pick;
            state <= ACK;
          end
        end
        ACK: begin
          bus.d_out <= {base, idx, 1'b0};
          bus.d_oe  <= vec_en;
          if (!bus.iorq) begin
            bus.d_oe <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.d_oe <= 1'b0;
          if (!bus.m1) state <= IDLE;
        end
        default: begin
          bus.d_oe <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_responder.sv
// tb/tb_int_responder.sv - scoreboard bench for int_responder
module tb_int_responder;
  localparam logic [15:0] CTRL = 16'hBF1F;
  localparam logic [15:0] VEC  = 16'hBE1F;

  logic clk28 = 1'b0;
  logic rst = 1'b1;
  logic clkcpu_ck = 1'b0;
  logic src_frame = 1'b0;
  logic src_line = 1'b0;
  logic src_ext = 1'b0;
  logic n_int;

  int_responder_if bus();

  int_responder dut (
    .clk28     (clk28),
    .rst       (rst),
    .clkcpu_ck (clkcpu_ck),
    .bus       (bus),
    .src_frame (src_frame),
    .src_line  (src_line),
    .src_ext   (src_ext),
    .n_int     (n_int)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  logic oe_prev = 1'b0;

  initial forever #5 clk28 = ~clk28;

  initial forever begin
    repeat (7) @(posedge clk28);
    #1 clkcpu_ck = 1'b1;
    @(posedge clk28);
    #1 clkcpu_ck = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk28);
    if (bus.d_oe === 1'b1 && !oe_prev) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_drive: got %02h expected no drive", bus.d_out);
      end else begin
        check("bus_data", {24'd0, bus.d_out}, {24'd0, exp_q.pop_front()});
      end
    end
    oe_prev = (bus.d_oe === 1'b1);
  end

  task automatic io_write(input logic [15:0] addr, input logic [7:0] data);
    @(negedge clk28);
    bus.a = addr; bus.d_in = data; bus.iorq = 1'b1; bus.wr = 1'b1;
    repeat (3) @(negedge clk28);
    bus.iorq = 1'b0; bus.wr = 1'b0;
    repeat (2) @(negedge clk28);
  endtask

  task automatic io_read(input logic [15:0] addr, input logic [7:0] exp);
    exp_q.push_back(exp);
    @(negedge clk28);
    bus.a = addr; bus.iorq = 1'b1; bus.rd = 1'b1;
    repeat (3) @(negedge clk28);
    bus.iorq = 1'b0; bus.rd = 1'b0;
    repeat (2) @(negedge clk28);
    check("rd_release", {31'd0, bus.d_oe}, 32'd0);
  endtask

  task automatic ack(input logic exp_oe, input logic [7:0] exp_vec);
    @(negedge clk28);
    bus.m1 = 1'b1;
    @(negedge clk28);
    bus.iorq = 1'b1;
    if (exp_oe) exp_q.push_back(exp_vec);
    repeat (4) @(negedge clk28);
    check("ack_oe", {31'd0, bus.d_oe}, {31'd0, exp_oe});
    bus.iorq = 1'b0;
    @(negedge clk28);
    check("ack_release", {31'd0, bus.d_oe}, 32'd0);
    bus.m1 = 1'b0;
    repeat (2) @(negedge clk28);
  endtask

  task automatic pulse(input logic [2:0] s);
    @(negedge clk28);
    {src_ext, src_line, src_frame} = s;
    @(negedge clk28);
    {src_ext, src_line, src_frame} = 3'b000;
    repeat (3) @(negedge clk28);
  endtask

  task automatic wait_strobe();
    int n = 0;
    @(negedge clk28);
    while (clkcpu_ck !== 1'b1 && n < 20) begin
      @(negedge clk28);
      n++;
    end
    @(negedge clk28);
  endtask

  initial begin
    int cnt;
    int guard;
    bus.m1 = 1'b0; bus.iorq = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
    bus.a = 16'h0000; bus.d_in = 8'h00;
    repeat (4) @(negedge clk28);
    check("reset_n_int", {31'd0, n_int}, 32'd1);
    check("reset_d_oe", {31'd0, bus.d_oe}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk28);
    io_read(CTRL, 8'h01);

    // frame request asserts at the next strobe and expires after 32 strobes
    pulse(3'b001);
    guard = 0;
    while (n_int !== 1'b0 && guard < 12) begin
      @(negedge clk28);
      guard++;
    end
    check("frame_n_int_low", {31'd0, n_int}, 32'd0);
    cnt = 0;
    guard = 0;
    while (n_int !== 1'b1 && guard < 400) begin
      if (clkcpu_ck === 1'b1) cnt++;
      @(negedge clk28);
      guard++;
    end
    check("frame_hold_strobes", cnt, 32);

    io_write(CTRL, 8'h0F);
    io_write(VEC, 8'h80);
    pulse(3'b110);
    ack(1'b1, 8'h82);
    io_read(CTRL, 8'h4F);
    ack(1'b1, 8'h84);
    io_read(CTRL, 8'h0F);

    pulse(3'b011);
    ack(1'b1, 8'h80);
    wait_strobe();
    check("line_keeps_n_int", {31'd0, n_int}, 32'd0);
    io_read(CTRL, 8'h2F);
    io_write(CTRL, 8'h2F);
    io_read(CTRL, 8'h0F);

    ack(1'b1, 8'h86);
    io_read(CTRL, 8'h0F);
    io_write(CTRL, 8'h07);
    ack(1'b0, 8'h00);
    io_read(CTRL, 8'h07);

    // ext set lands in the same cycle as the write that clears it
    @(negedge clk28);
    src_ext = 1'b1;
    @(negedge clk28);
    bus.a = CTRL; bus.d_in = 8'h4F; bus.iorq = 1'b1; bus.wr = 1'b1;
    repeat (3) @(negedge clk28);
    bus.iorq = 1'b0; bus.wr = 1'b0; src_ext = 1'b0;
    repeat (2) @(negedge clk28);
    io_read(CTRL, 8'h4F);
    wait_strobe();
    check("ext_n_int", {31'd0, n_int}, 32'd0);

    io_write(VEC, 8'h80);
    pulse(3'b010);
    @(negedge clk28);
    bus.m1 = 1'b1;
    @(negedge clk28);
    bus.iorq = 1'b1;
    exp_q.push_back(8'h82);
    repeat (4) @(negedge clk28);
    rst = 1'b1;
    @(negedge clk28);
    check("rst_ack_d_oe", {31'd0, bus.d_oe}, 32'd0);
    check("rst_ack_n_int", {31'd0, n_int}, 32'd1);
    rst = 1'b0;
    repeat (3) @(negedge clk28);
    check("rst_no_respond", {31'd0, bus.d_oe}, 32'd0);
    bus.iorq = 1'b0;
    @(negedge clk28);
    bus.m1 = 1'b0;
    repeat (2) @(negedge clk28);
    io_read(CTRL, 8'h01);
    io_write(CTRL, 8'h08);
    ack(1'b1, 8'hFE);

    repeat (4) @(negedge clk28);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
